// File: rtl/lstm_ew_pkg.sv
// rtl/lstm_ew_pkg.sv - fixed-point helpers and activation mode names for the LSTM element-wise engine
package lstm_ew_pkg;

    localparam string ACT_NONE     = "none";
    localparam string ACT_HARDTANH = "hardtanh";

    // Helpers work on 64-bit signed values; callers truncate with a size cast.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int frac);
        return (x + (64'sd1 <<< (frac - 1))) >>> frac;
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    function automatic logic signed [63:0] round_sat(input logic signed [63:0] x, input int frac, input int width);
        return saturate(round_shift(x, frac), width);
    endfunction

endpackage

// File: rtl/lstm_ew_engine_ew_lane.sv
// rtl/lstm_ew_engine_ew_lane.sv - one lane: cell update, activation/output gate, dense-layer term
module ew_lane
    import lstm_ew_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    FRAC_WIDTH = 12,
    parameter string ACT_MODE   = ACT_NONE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] f_in,
    input  logic signed [DATA_WIDTH-1:0] i_in,
    input  logic signed [DATA_WIDTH-1:0] g_in,
    input  logic signed [DATA_WIDTH-1:0] o_in,
    input  logic signed [DATA_WIDTH-1:0] c_prev_in,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    output logic signed [DATA_WIDTH-1:0] cell_out,
    output logic                         cell_valid,
    output logic signed [DATA_WIDTH-1:0] term,
    output logic                         term_valid
);
    localparam int DW = DATA_WIDTH;
    localparam int W2 = 2 * DATA_WIDTH;
    localparam int W3 = W2 + 1;
    localparam bit USE_HT = (ACT_MODE == ACT_HARDTANH);
    localparam logic signed [63:0] ONE = 64'sd1 <<< FRAC_WIDTH;

    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic signed [W2-1:0] p1_q, p1_d, p2_q, p2_d;
    logic signed [DW-1:0] o1_q, o1_d, o2_q, o2_d;
    logic signed [DW-1:0] w1_q, w1_d, w2_q, w2_d, w3_q, w3_d;
    logic signed [DW-1:0] c_q, c_d, h_q, h_d;
    logic signed [W3-1:0] sum;
    logic signed [63:0]   act;

    always_comb begin
        v1_d = in_valid;
        v2_d = v1_q;
        v3_d = v2_q;
        p1_d = W2'(f_in) * W2'(c_prev_in);
        p2_d = W2'(i_in) * W2'(g_in);
        o1_d = o_in;
        o2_d = o1_q;
        w1_d = w_in;
        w2_d = w1_q;
        w3_d = w2_q;
        sum  = W3'(p1_q) + W3'(p2_q);
        c_d  = DW'(round_sat(64'(sum), FRAC_WIDTH, DW));
        act  = 64'(c_q);
        if (USE_HT) begin
            if (act > ONE)       act = ONE;
            else if (act < -ONE) act = -ONE;
        end
        h_d  = DW'(round_sat(act * 64'(o2_q), FRAC_WIDTH, DW));
        term = DW'(round_sat(64'(h_q) * 64'(w3_q), FRAC_WIDTH, DW));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            c_q  <= '0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
            v3_q <= v3_d;
            c_q  <= c_d;
        end
    end

    // Pure datapath: qualified by the valid chain, so no reset needed.
    always_ff @(posedge clk) begin
        p1_q <= p1_d;
        p2_q <= p2_d;
        o1_q <= o1_d;
        o2_q <= o2_d;
        w1_q <= w1_d;
        w2_q <= w2_d;
        w3_q <= w3_d;
        h_q  <= h_d;
    end

    assign cell_out   = c_q;
    assign cell_valid = v2_q;
    assign term_valid = v3_q;

endmodule

// File: rtl/lstm_ew_engine.sv
// rtl/lstm_ew_engine.sv - LSTM element-wise engine: LANES parallel lanes plus frame dot-product accumulator
module lstm_ew_engine
    import lstm_ew_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    FRAC_WIDTH = 12,
    parameter int    HIDDEN     = 15,
    parameter int    LANES      = 5,
    parameter string ACT_MODE   = ACT_NONE
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [LANES*DATA_WIDTH-1:0]        f_in,
    input  logic [LANES*DATA_WIDTH-1:0]        i_in,
    input  logic [LANES*DATA_WIDTH-1:0]        g_in,
    input  logic [LANES*DATA_WIDTH-1:0]        o_in,
    input  logic [LANES*DATA_WIDTH-1:0]        c_prev_in,
    input  logic [LANES*DATA_WIDTH-1:0]        w_in,
    output logic [LANES*DATA_WIDTH-1:0]        cell_out,
    output logic                               cell_valid,
    output logic signed [2*DATA_WIDTH-1:0]     acc_out,
    output logic                               acc_valid,
    output logic                               busy
);
    localparam int DW    = DATA_WIDTH;
    localparam int W2    = 2 * DATA_WIDTH;
    localparam int BEATS = HIDDEN / LANES;
    localparam int CW    = $clog2(BEATS + 1);

    if (HIDDEN % LANES != 0) begin : g_bad_hidden
        $error("HIDDEN must be a multiple of LANES");
    end
    if (ACT_MODE != ACT_NONE && ACT_MODE != ACT_HARDTANH) begin : g_bad_act
        $error("ACT_MODE must be none or hardtanh");
    end

    logic                 accept;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           first_q, first_d, last_q, last_d;
    logic signed [W2-1:0] acc_q, acc_d, beat_sum;
    logic                 acc_valid_q, acc_valid_d;
    logic [LANES-1:0]     lane_cell_valid, lane_term_valid;
    logic signed [DW-1:0] lane_term [LANES];
    logic                 term_valid;

    assign in_ready   = (cnt_q != CW'(BEATS));
    assign accept     = in_valid && in_ready;
    assign cell_valid = &lane_cell_valid;
    assign term_valid = &lane_term_valid;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ew_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .FRAC_WIDTH(FRAC_WIDTH),
            .ACT_MODE  (ACT_MODE)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (accept),
            .f_in      (f_in[k*DW +: DW]),
            .i_in      (i_in[k*DW +: DW]),
            .g_in      (g_in[k*DW +: DW]),
            .o_in      (o_in[k*DW +: DW]),
            .c_prev_in (c_prev_in[k*DW +: DW]),
            .w_in      (w_in[k*DW +: DW]),
            .cell_out  (cell_out[k*DW +: DW]),
            .cell_valid(lane_cell_valid[k]),
            .term      (lane_term[k]),
            .term_valid(lane_term_valid[k])
        );
    end

    always_comb begin
        cnt_d   = cnt_q;
        first_d = {first_q[1:0], accept && (cnt_q == '0)};
        last_d  = {last_q[1:0], accept && (cnt_q == CW'(BEATS - 1))};
        if (acc_valid_q)  cnt_d = '0;
        else if (accept)  cnt_d = cnt_q + CW'(1);

        beat_sum = '0;
        for (int k = 0; k < LANES; k++) beat_sum = beat_sum + W2'(lane_term[k]);

        acc_d       = acc_q;
        acc_valid_d = 1'b0;
        // The first beat's sum overwrites the accumulator, so frames need no clear cycle.
        if (term_valid) begin
            if (first_q[2]) acc_d = beat_sum;
            else            acc_d = W2'(saturate(64'(acc_q) + 64'(beat_sum), W2));
            acc_valid_d = last_q[2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            acc_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    assign acc_out   = acc_q;
    assign acc_valid = acc_valid_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: doc/lstm_ew_engine.md
LSTM_EW_ENGINE -- requirements
Module: lstm_ew_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: signed fixed-point word width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 12: fractional bits (1.0 = 2^FRAC_WIDTH).
REQ-003 SHALL have parameter HIDDEN, default 15: hidden units per frame.
REQ-004 SHALL have parameter LANES, default 5: elements processed per beat; HIDDEN % LANES == 0, else elaboration error.
REQ-005 SHALL have parameter ACT_MODE, default "none": "none" or "hardtanh", the activation applied to the new cell state before the output gate.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 in_valid  input  1  beat of LANES elements present.
REQ-009 in_ready  output  1  engine accepts a beat.
REQ-010 f_in, i_in, g_in, o_in  input  LANES*DATA_WIDTH each  signed forget/input/candidate/output gate values; lane k is at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 c_prev_in  input  LANES*DATA_WIDTH  signed previous cell state.
REQ-012 w_in  input  LANES*DATA_WIDTH  signed dense-layer weights.
REQ-013 cell_out  output  LANES*DATA_WIDTH  new cell state for one beat.
REQ-014 cell_valid  output  1  cell_out is valid.
REQ-015 acc_out  output  2*DATA_WIDTH  signed frame dot product sum(h*w).
REQ-016 acc_valid  output  1  one-cycle pulse; acc_out is final.
REQ-017 busy  output  1  a frame is in progress or the pipeline is non-empty.

Function
REQ-018 A beat SHALL be accepted when in_valid && in_ready.
REQ-019 in_ready SHALL be 1 while fewer than HIDDEN/LANES beats of the current frame are accepted, then 0 until the cycle after the acc_valid pulse.
REQ-020 in_valid while in_ready=0 SHALL be ignored.
REQ-021 Pipe stage 1 SHALL register p1=f*c_prev and p2=i*g per lane, full 2*DATA_WIDTH signed.
REQ-022 Pipe stage 2 SHALL compute c=sat((p1+p2+2^(FRAC_WIDTH-1))>>>FRAC_WIDTH) to DATA_WIDTH; the sum SHALL use 2*DATA_WIDTH+1 bits.
REQ-023 cell_out/cell_valid SHALL appear exactly 2 cycles after acceptance, in beat order.
REQ-024 Pipe stage 3 SHALL compute h=sat(round(act(c)*o)) with the REQ-022 rule; hardtanh clamps c to [-1.0, +1.0].
REQ-025 Pipe stage 4 SHALL compute term=round(h*w) to DATA_WIDTH, summing LANES terms in 2*DATA_WIDTH signed.
REQ-026 The accumulator SHALL add each beat sum, saturating at 2*DATA_WIDTH signed limits without wrap.
REQ-027 acc_valid SHALL pulse 4 cycles after the last beat of a frame is accepted; acc_out SHALL hold until the next frame's first sum arrives.
REQ-028 The accumulator SHALL clear on the first beat of every frame, with no dedicated clear cycle.
REQ-029 Gaps between beats (in_valid=0) SHALL be allowed; latency is measured per beat.
REQ-030 Saturation SHALL produce +(2^(DATA_WIDTH-1)-1) or -2^(DATA_WIDTH-1) exactly.

Reset
REQ-031 With rst=0 at a clock edge, the engine SHALL set in_ready=1, cell_valid=0, acc_valid=0, busy=0, acc_out=0, cell_out=0, beat counter=0, and clear all pipeline valid bits.
REQ-032 Reset mid-frame SHALL discard in-flight beats; no acc_valid SHALL follow for that frame.
REQ-033 Datapath registers other than those in REQ-031 SHALL need no reset.

Structure
REQ-034 A shared package SHALL hold the fixed-point helpers (round-shift, saturate) and the ACT_MODE constants.
REQ-035 A single sub-module ew_lane SHALL implement stages 1-4 for one lane; lstm_ew_engine SHALL instantiate it LANES times and add the beat-sum, accumulator and beat counter.

Verification
REQ-036 One beat with f=4096, c_prev=2048, i=2048, g=2048 in all lanes SHALL give cell_out lanes = 3072 at cycle +2.
REQ-037 f=c_prev=i=g=32767 SHALL give cell_out=32767; all four = -32768 SHALL give 32767 (the products are positive).
REQ-038 A full frame (3 beats) with o=4096, w=4096, c=4096, ACT_MODE "none" SHALL give acc_out=15*4096=61440, with acc_valid 4 cycles after the third beat.
REQ-039 ACT_MODE "hardtanh", c=12288, o=4096 SHALL give h=4096 per lane.
REQ-040 A frame with 2-cycle in_valid gaps SHALL give the same acc_out as back-to-back beats, and in_ready SHALL fall after beat 3.
REQ-041 rst=0 after beat 2 then a new full frame SHALL give exactly one acc_valid, carrying only the second frame's value.
